// File: rtl/mac32_txn_tracker.sv
// Pairs MAC operand triples with their in-order results and retires {A,B,C,Result} on a valid/ready port.
// Optional stall watchdog enabled by defining MAC32_TRACK_TIMEOUT_EN.
module mac32_txn_tracker #(
  parameter int unsigned PARM_XLEN    = 32,
  parameter int unsigned PARM_DEPTH   = 8,
  parameter int unsigned PARM_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  input  logic [PARM_XLEN-1:0]          A_i,
  input  logic [PARM_XLEN-1:0]          B_i,
  input  logic [PARM_XLEN-1:0]          C_i,
  input  logic                          res_valid_i,
  input  logic [PARM_XLEN-1:0]          Result_i,
  output logic                          txn_valid_o,
  input  logic                          txn_ready_i,
  output logic [PARM_XLEN-1:0]          txn_A_o,
  output logic [PARM_XLEN-1:0]          txn_B_o,
  output logic [PARM_XLEN-1:0]          txn_C_o,
  output logic [PARM_XLEN-1:0]          txn_result_o,
  output logic [$clog2(PARM_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          overflow_err_o,
  output logic                          orphan_err_o,
  output logic                          timeout_err_o
);

  localparam int unsigned AW = $clog2(PARM_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PARM_XLEN-1:0]  r_a   [PARM_DEPTH];
  logic [PARM_XLEN-1:0]  r_b   [PARM_DEPTH];
  logic [PARM_XLEN-1:0]  r_c   [PARM_DEPTH];
  logic [PARM_XLEN-1:0]  r_res [PARM_DEPTH];
  logic [PARM_DEPTH-1:0] r_done;
  logic [PW-1:0]         r_wr, r_cm, r_rd;
  logic                  r_ovf, r_orph;

  logic [PW-1:0] w_count;
  logic [AW-1:0] w_wr_idx, w_cm_idx, w_rd_idx;
  logic          w_full, w_pending, w_head_vld, w_out_en;
  logic          w_retire, w_issue, w_drop, w_complete, w_orphan;

  always_comb begin
    w_wr_idx   = r_wr[AW-1:0];
    w_cm_idx   = r_cm[AW-1:0];
    w_rd_idx   = r_rd[AW-1:0];
    w_count    = r_wr - r_rd;
    w_full     = (w_count == PW'(PARM_DEPTH));
    w_pending  = (r_cm != r_wr);
    w_head_vld = r_done[w_rd_idx] && (r_rd != r_cm);
    w_out_en   = rst_n && w_head_vld;
    w_retire   = w_out_en && txn_ready_i;
    // A retire frees the slot this cycle, so a full tracker can still accept an issue.
    w_issue    = issue_valid_i && (!w_full || w_retire);
    w_drop     = issue_valid_i && w_full && !w_retire;
    // Pointer compare is pre-update: a same-cycle issue cannot absorb this result.
    w_complete = res_valid_i && w_pending;
    w_orphan   = res_valid_i && !w_pending;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_cm   <= '0;
      r_rd   <= '0;
      r_done <= '0;
      r_ovf  <= 1'b0;
      r_orph <= 1'b0;
    end else begin
      if (w_retire) begin
        r_done[w_rd_idx] <= 1'b0;
        r_rd             <= r_rd + PW'(1);
      end
      if (w_issue) begin
        r_a[w_wr_idx]    <= A_i;
        r_b[w_wr_idx]    <= B_i;
        r_c[w_wr_idx]    <= C_i;
        r_done[w_wr_idx] <= 1'b0;
        r_wr             <= r_wr + PW'(1);
      end
      if (w_complete) begin
        r_res[w_cm_idx]  <= Result_i;
        r_done[w_cm_idx] <= 1'b1;
        r_cm             <= r_cm + PW'(1);
      end
      if (w_drop)   r_ovf  <= 1'b1;
      if (w_orphan) r_orph <= 1'b1;
    end
  end

`ifdef MAC32_TRACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(PARM_TIMEOUT) + 1;

  logic [TW-1:0] r_wd;
  logic          r_tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (!w_pending || w_complete) begin
        r_wd <= '0;
      end else if (r_wd != TW'(PARM_TIMEOUT)) begin
        r_wd <= r_wd + TW'(1);
      end
      if (w_pending && !w_complete && (r_wd == TW'(PARM_TIMEOUT - 1))) begin
        r_tmo <= 1'b1;
      end
    end
  end

  assign timeout_err_o = rst_n && r_tmo;
`else
  assign timeout_err_o = 1'b0;
`endif

  // Outputs are held low while reset is asserted so the reset cycle itself shows nothing.
  assign txn_valid_o    = w_out_en;
  assign txn_A_o        = w_out_en ? r_a[w_rd_idx]   : '0;
  assign txn_B_o        = w_out_en ? r_b[w_rd_idx]   : '0;
  assign txn_C_o        = w_out_en ? r_c[w_rd_idx]   : '0;
  assign txn_result_o   = w_out_en ? r_res[w_rd_idx] : '0;
  assign count_o        = rst_n ? w_count : '0;
  assign full_o         = rst_n && w_full;
  assign overflow_err_o = rst_n && r_ovf;
  assign orphan_err_o   = rst_n && r_orph;

endmodule

// File: tb/tb_mac32_txn_tracker.sv
// Directed self-checking bench for mac32_txn_tracker.
module tb_mac32_txn_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i;
  logic [31:0] A_i, B_i, C_i;
  logic        res_valid_i;
  logic [31:0] Result_i;
  logic        txn_valid_o;
  logic        txn_ready_i;
  logic [31:0] txn_A_o, txn_B_o, txn_C_o, txn_result_o;
  logic [3:0]  count_o;
  logic        full_o, overflow_err_o, orphan_err_o, timeout_err_o;

  int checks = 0;
  int errors = 0;
  logic exp_tmo;

  mac32_txn_tracker #(
    .PARM_XLEN   (32),
    .PARM_DEPTH  (8),
    .PARM_TIMEOUT(64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid_i),
    .A_i           (A_i),
    .B_i           (B_i),
    .C_i           (C_i),
    .res_valid_i   (res_valid_i),
    .Result_i      (Result_i),
    .txn_valid_o   (txn_valid_o),
    .txn_ready_i   (txn_ready_i),
    .txn_A_o       (txn_A_o),
    .txn_B_o       (txn_B_o),
    .txn_C_o       (txn_C_o),
    .txn_result_o  (txn_result_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .overflow_err_o(overflow_err_o),
    .orphan_err_o  (orphan_err_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; issue_valid_i = 0; A_i = 0; B_i = 0; C_i = 0;
    res_valid_i = 0; Result_i = 0; txn_ready_i = 0;
    tick(); tick();
    chk("rst_valid", txn_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_errs", {overflow_err_o, orphan_err_o, timeout_err_o}, 0);
    chk("rst_data", txn_A_o | txn_result_o, 0);
    rst_n = 1'b1;

    // Single transaction, result three cycles after issue.
    issue_valid_i = 1; A_i = 32'h3F800000; B_i = 32'h40000000; C_i = 32'h40400000;
    tick();
    issue_valid_i = 0;
    chk("t1_count_issue", count_o, 1);
    chk("t1_valid_early", txn_valid_o, 0);
    tick(); tick();
    chk("t1_valid_pending", txn_valid_o, 0);
    res_valid_i = 1; Result_i = 32'h40E00000;
    tick();
    res_valid_i = 0;
    chk("t1_valid", txn_valid_o, 1);
    chk("t1_A", txn_A_o, 32'h3F800000);
    chk("t1_B", txn_B_o, 32'h40000000);
    chk("t1_C", txn_C_o, 32'h40400000);
    chk("t1_res", txn_result_o, 32'h40E00000);
    txn_ready_i = 1;
    tick();
    txn_ready_i = 0;
    chk("t1_valid_after", txn_valid_o, 0);
    chk("t1_count_after", count_o, 0);

    // Fill, overflow, complete all, drain in order.
    for (int i = 0; i < 8; i++) begin
      issue_valid_i = 1; A_i = 32'h10000000 + i; B_i = 32'h20000000 + i; C_i = 32'h30000000 + i;
      tick();
    end
    chk("t2_full", full_o, 1);
    chk("t2_count", count_o, 8);
    chk("t2_no_ovf", overflow_err_o, 0);
    A_i = 32'hDEADBEEF;
    tick();
    issue_valid_i = 0;
    chk("t2_ovf", overflow_err_o, 1);
    chk("t2_count_ovf", count_o, 8);
    for (int i = 0; i < 8; i++) begin
      res_valid_i = 1; Result_i = 32'hA0000000 + i;
      tick();
    end
    res_valid_i = 0;
    chk("t2_orphan_none", orphan_err_o, 0);
    txn_ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", txn_valid_o, 1);
      chk("t2_drain_A", txn_A_o, 32'h10000000 + i);
      chk("t2_drain_C", txn_C_o, 32'h30000000 + i);
      chk("t2_drain_res", txn_result_o, 32'hA0000000 + i);
      tick();
    end
    txn_ready_i = 0;
    chk("t2_empty_valid", txn_valid_o, 0);
    chk("t2_empty_count", count_o, 0);

    // Orphan result on empty tracker.
    res_valid_i = 1; Result_i = 32'h55555555;
    tick();
    res_valid_i = 0;
    chk("t3_orphan", orphan_err_o, 1);
    chk("t3_orphan_valid", txn_valid_o, 0);
    chk("t3_orphan_count", count_o, 0);

    // Same-cycle issue and result on empty: result is orphaned, issue still accepted.
    do_reset();
    chk("t3b_cleared", {overflow_err_o, orphan_err_o}, 0);
    issue_valid_i = 1; A_i = 32'h11111111; B_i = 32'h22222222; C_i = 32'h33333333;
    res_valid_i = 1; Result_i = 32'h66666666;
    tick();
    issue_valid_i = 0;
    Result_i = 32'h77777777;
    chk("t3b_orphan", orphan_err_o, 1);
    chk("t3b_count", count_o, 1);
    chk("t3b_valid", txn_valid_o, 0);
    tick();
    res_valid_i = 0;
    chk("t3b_res", txn_result_o, 32'h77777777);
    txn_ready_i = 1;
    tick();
    txn_ready_i = 0;
    chk("t3b_count_after", count_o, 0);

    // Full, head done, retire plus issue in the same cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue_valid_i = 1; A_i = 32'h40000000 + i;
      tick();
    end
    issue_valid_i = 0;
    res_valid_i = 1; Result_i = 32'hB0000000;
    tick();
    res_valid_i = 0;
    chk("t4_head_valid", txn_valid_o, 1);
    chk("t4_full_before", full_o, 1);
    issue_valid_i = 1; A_i = 32'h4000000F; txn_ready_i = 1;
    tick();
    issue_valid_i = 0; txn_ready_i = 0;
    chk("t4_count", count_o, 8);
    chk("t4_full", full_o, 1);
    chk("t4_no_ovf", overflow_err_o, 0);
    chk("t4_next_valid", txn_valid_o, 0);

    // Mid-operation reset with 5 in flight.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue_valid_i = 1; A_i = 32'h50000000 + i;
      tick();
    end
    issue_valid_i = 0;
    res_valid_i = 1; Result_i = 32'hC0000000;
    tick();
    res_valid_i = 0;
    chk("t5_count_pre", count_o, 5);
    chk("t5_valid_pre", txn_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cycle", {txn_valid_o, count_o, full_o}, 0);
    tick();
    rst_n = 1'b1;
    chk("t5_after_rst", {txn_valid_o, count_o, full_o, txn_A_o}, 0);
    tick();
    chk("t5_idle", {txn_valid_o, count_o, orphan_err_o}, 0);
    res_valid_i = 1; Result_i = 32'hC0000001;
    tick();
    res_valid_i = 0;
    chk("t5_orphan", orphan_err_o, 1);
    chk("t5_orphan_valid", txn_valid_o, 0);

    // Watchdog: one issue, no result.
`ifdef MAC32_TRACK_TIMEOUT_EN
    exp_tmo = 1'b1;
`else
    exp_tmo = 1'b0;
`endif
    do_reset();
    issue_valid_i = 1; A_i = 32'h60000000;
    tick();
    issue_valid_i = 0;
    for (int i = 0; i < 63; i++) tick();
    chk("t6_tmo_before", timeout_err_o, 0);
    tick();
    chk("t6_tmo", timeout_err_o, exp_tmo);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_tmo_sticky", timeout_err_o, exp_tmo);
    chk("t6_count", count_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
